// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between the ALU and memory-load writeback paths
module regfile_write_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wa,
  input  logic [31:0] mem_wd,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic [14:0] pending,
  output logic        pc_write_err
);
  logic        alu_full_q, alu_full_d, mem_full_q, mem_full_d;
  logic [3:0]  alu_wa_q, alu_wa_d, mem_wa_q, mem_wa_d;
  logic [31:0] alu_wd_q, alu_wd_d, mem_wd_q, mem_wd_d;
  logic        last_grant_q, last_grant_d;
  logic        pc_write_err_q, pc_write_err_d;
  logic        grant_alu, grant_mem, alu_acc, mem_acc, alu_pc, mem_pc;
  // Grant from the full flags only; on a tie the source not served last wins unless ALU has fixed priority
  always_comb begin
    grant_alu = alu_full_q & (!mem_full_q | !FAIR | last_grant_q);
    grant_mem = mem_full_q & !grant_alu;
    we3       = grant_alu | grant_mem;
    wa3       = grant_alu ? alu_wa_q : grant_mem ? mem_wa_q : 4'd0;
    wd3       = grant_alu ? alu_wd_q : grant_mem ? mem_wd_q : 32'd0;
    alu_ready = !alu_full_q | grant_alu;
    mem_ready = !mem_full_q | grant_mem;
    pc_write_err = pc_write_err_q;
  end
  // Accept into the holding registers, drop R15 writes, and retire the granted entry
  always_comb begin
    alu_acc        = alu_valid & alu_ready;
    mem_acc        = mem_valid & mem_ready;
    alu_pc         = alu_wa == 4'd15;
    mem_pc         = mem_wa == 4'd15;
    alu_full_d     = alu_acc ? !alu_pc : alu_full_q & !grant_alu;
    mem_full_d     = mem_acc ? !mem_pc : mem_full_q & !grant_mem;
    alu_wa_d       = (alu_acc & !alu_pc) ? alu_wa : alu_wa_q;
    alu_wd_d       = (alu_acc & !alu_pc) ? alu_wd : alu_wd_q;
    mem_wa_d       = (mem_acc & !mem_pc) ? mem_wa : mem_wa_q;
    mem_wd_d       = (mem_acc & !mem_pc) ? mem_wd : mem_wd_q;
    last_grant_d   = we3 ? grant_mem : last_grant_q;
    pc_write_err_d = (alu_acc & alu_pc) | (mem_acc & mem_pc);
  end
  // Per-register mask of buffered writes not yet committed, for decode hazard checks
  always_comb begin
    pending = '0;
    for (int r = 0; r < 15; r++)
      pending[r] = (alu_full_q && alu_wa_q == 4'(r)) || (mem_full_q && mem_wa_q == 4'(r));
  end
  // State registers; reset discards both holding registers and lets ALU win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_full_q     <= 1'b0;
      mem_full_q     <= 1'b0;
      alu_wa_q       <= '0;
      alu_wd_q       <= '0;
      mem_wa_q       <= '0;
      mem_wd_q       <= '0;
      last_grant_q   <= 1'b1;
      pc_write_err_q <= 1'b0;
    end else begin
      alu_full_q     <= alu_full_d;
      mem_full_q     <= mem_full_d;
      alu_wa_q       <= alu_wa_d;
      alu_wd_q       <= alu_wd_d;
      mem_wa_q       <= mem_wa_d;
      mem_wd_q       <= mem_wd_d;
      last_grant_q   <= last_grant_d;
      pc_write_err_q <= pc_write_err_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: round-robin and fixed-priority instances checked against a queue-level model
module tb_regfile_write_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_wa = '0, mem_wa = '0;
  logic [31:0] alu_wd = '0, mem_wd = '0;
  logic        alu_ready [2], mem_ready [2], we3 [2], pc_err [2];
  logic [3:0]  wa3 [2];
  logic [31:0] wd3 [2];
  logic [14:0] pending [2];
  int n_checks = 0, n_fail = 0;
  bit          mfull [2][2];
  logic [3:0]  mwa [2][2];
  logic [31:0] mwd [2][2];
  int          mlast [2];
  bit          merr [2];
  logic [31:0] mrf [2][16], orf [2][16];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.FAIR(1'b1)) dut_fair (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready[0]), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready[0]), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .we3(we3[0]), .wa3(wa3[0]), .wd3(wd3[0]), .pending(pending[0]), .pc_write_err(pc_err[0]));

  regfile_write_arbiter #(.FAIR(1'b0)) dut_prio (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready[1]), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready[1]), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .we3(we3[1]), .wa3(wa3[1]), .wd3(wd3[1]), .pending(pending[1]), .pc_write_err(pc_err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: each source owns a one-slot buffer; instance 0 alternates on ties, instance 1 always picks ALU.
  function automatic int mgrant(input int d);
    if (mfull[d][0] && mfull[d][1]) return (d == 0 && mlast[d] == 0) ? 1 : 0;
    if (mfull[d][0]) return 0;
    if (mfull[d][1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mfull[d][0] = 0;
      mfull[d][1] = 0;
      mlast[d] = 1;
      merr[d] = 0;
      for (int r = 0; r < 16; r++) begin
        mrf[d][r] = '0;
        orf[d][r] = '0;
      end
    end
  endtask

  task automatic model_step(input int d);
    int g;
    bit rdy0, rdy1;
    g = mgrant(d);
    rdy0 = !mfull[d][0] || g == 0;
    rdy1 = !mfull[d][1] || g == 1;
    if (g >= 0) begin
      mrf[d][mwa[d][g]] = mwd[d][g];
      mfull[d][g] = 0;
      mlast[d] = g;
    end
    merr[d] = 0;
    if (alu_valid && rdy0) begin
      if (alu_wa == 4'd15) merr[d] = 1;
      else begin mfull[d][0] = 1; mwa[d][0] = alu_wa; mwd[d][0] = alu_wd; end
    end
    if (mem_valid && rdy1) begin
      if (mem_wa == 4'd15) merr[d] = 1;
      else begin mfull[d][1] = 1; mwa[d][1] = mem_wa; mwd[d][1] = mem_wd; end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [14:0] ep;
      g = mgrant(d);
      ep = '0;
      for (int s = 0; s < 2; s++) if (mfull[d][s]) ep[mwa[d][s]] = 1'b1;
      chk($sformatf("we3[%0d]", d), 32'(we3[d]), 32'(g >= 0));
      chk($sformatf("wa3[%0d]", d), 32'(wa3[d]), (g >= 0) ? 32'(mwa[d][g]) : 32'd0);
      chk($sformatf("wd3[%0d]", d), wd3[d], (g >= 0) ? mwd[d][g] : 32'd0);
      chk($sformatf("pending[%0d]", d), 32'(pending[d]), 32'(ep));
      chk($sformatf("alu_ready[%0d]", d), 32'(alu_ready[d]), 32'(!mfull[d][0] || g == 0));
      chk($sformatf("mem_ready[%0d]", d), 32'(mem_ready[d]), 32'(!mfull[d][1] || g == 1));
      chk($sformatf("pc_err[%0d]", d), 32'(pc_err[d]), 32'(merr[d]));
      if (we3[d] === 1'b1) orf[d][wa3[d]] = wd3[d];
    end
  endtask

  task automatic drive(input bit av, input logic [3:0] aw, input logic [31:0] ad,
                       input bit mv, input logic [3:0] mw, input logic [31:0] md);
    alu_valid = av; alu_wa = aw; alu_wd = ad;
    mem_valid = mv; mem_wa = mw; mem_wd = md;
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic cyc(input bit av, input logic [3:0] aw, input logic [31:0] ad,
                     input bit mv, input logic [3:0] mw, input logic [31:0] md);
    drive(av, aw, ad, mv, mw, md);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_we3[%0d]", d), 32'(we3[d]), 32'd0);
      chk($sformatf("rst_pending[%0d]", d), 32'(pending[d]), 32'd0);
      chk($sformatf("rst_alu_ready[%0d]", d), 32'(alu_ready[d]), 32'd1);
      chk($sformatf("rst_mem_ready[%0d]", d), 32'(mem_ready[d]), 32'd1);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    // single ALU write
    cyc(1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("single_we3", 32'(we3[0]), 32'd1);
    chk("single_wa3", 32'(wa3[0]), 32'd3);
    chk("single_wd3", wd3[0], 32'hDEADBEEF);
    chk("single_pending", 32'(pending[0]), 32'h8);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("single_pending_clr", 32'(pending[0]), 32'd0);
    tick();
    // reset with both holding registers full
    cyc(1, 4'd7, 32'hA7, 1, 4'd8, 32'hB8);
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    // contention: both valid every cycle
    cyc(1, 4'd1, 32'h100, 1, 4'd2, 32'h200);
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'd1, 32'h100, 1, 4'd2, 32'h200);
      chk("fair_wa3_seq", 32'(wa3[0]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("fair_alu_ready", 32'(alu_ready[0]), 32'(k % 2 == 0));
      chk("fair_mem_ready", 32'(mem_ready[0]), 32'(k % 2 == 1));
      chk("prio_wa3", 32'(wa3[1]), 32'd1);
      chk("prio_mem_ready", 32'(mem_ready[1]), 32'd0);
      tick();
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    // same register from both sources
    do_reset();
    cyc(1, 4'd5, 32'h11, 1, 4'd5, 32'h22);
    drive(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("same_first[%0d]", d), wd3[d], 32'h11);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("same_second[%0d]", d), wd3[d], 32'h22);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("same_final_r5[%0d]", d), orf[d][5], 32'h22);
    tick();
    // R15 from both sources at once
    cyc(1, 4'd15, 32'h5, 1, 4'd15, 32'h6);
    drive(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pc_err_pulse[%0d]", d), 32'(pc_err[d]), 32'd1);
      chk($sformatf("pc_we3[%0d]", d), 32'(we3[d]), 32'd0);
      chk($sformatf("pc_pending[%0d]", d), 32'(pending[d]), 32'd0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("pc_err_end[%0d]", d), 32'(pc_err[d]), 32'd0);
    tick();
    // random traffic
    repeat (400)
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 15; r++)
        chk($sformatf("rf[%0d][%0d]", d, r), orf[d][r], mrf[d][r]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
